// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the bubble encoding and the fetch FSM state type.
package cpu_pkg;
  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/adder.sv
// Plain W-bit modulo adder; the carry out is intentionally dropped.
module adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding a one-cycle-latency synchronous ROM.
// Optional output redirect_count is built when FETCH_REDIRECT_COUNT_EN is defined.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               nop,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_q,
  output logic [ADDR_W-1:0]  pc_decode,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               valid_out
`ifdef FETCH_REDIRECT_COUNT_EN
  ,
  output logic [15:0]        redirect_count
`endif
);

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_fetch_reg, pc_fetch_next;
  logic [ADDR_W-1:0]  pc_pend_reg, pc_pend_next;
  logic [ADDR_W-1:0]  pc_decode_reg, pc_decode_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic               valid_reg, valid_next;
  logic [ADDR_W-1:0]  pc_inc;

  adder #(.W(ADDR_W)) u_pc_inc (
    .a   (pc_fetch_reg),
    .b   (16'd1),
    .sum (pc_inc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FILL;
      pc_fetch_reg  <= RESET_PC;
      pc_pend_reg   <= RESET_PC;
      pc_decode_reg <= '0;
      instr_reg     <= NOP_INSTR;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_fetch_reg  <= pc_fetch_next;
      pc_pend_reg   <= pc_pend_next;
      pc_decode_reg <= pc_decode_next;
      instr_reg     <= instr_next;
      valid_reg     <= valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_fetch_next  = pc_fetch_reg;
    pc_pend_next   = pc_pend_reg;
    pc_decode_next = pc_decode_reg;
    instr_next     = instr_reg;
    valid_next     = valid_reg;
    // While stalled in RUN, keep re-reading the pending word so rom_q stays valid.
    rom_address    = (state_reg == RUN && nop) ? pc_pend_reg : pc_fetch_reg;

    if (branch_taken) begin
      pc_fetch_next = branch_address;
      state_next    = FILL;
      instr_next    = NOP_INSTR;
      valid_next    = 1'b0;
    end else if (state_reg == FILL) begin
      // A stall during FILL holds everything; advancing to RUN with pc_pend equal
      // to pc_fetch would deliver the target word twice.
      if (!nop) begin
        pc_pend_next  = pc_fetch_reg;
        pc_fetch_next = pc_inc;
        state_next    = RUN;
      end
    end else if (!nop) begin
      instr_next     = rom_q;
      pc_decode_next = pc_pend_reg;
      valid_next     = 1'b1;
      pc_pend_next   = pc_fetch_reg;
      pc_fetch_next  = pc_inc;
    end
  end

  assign pc_decode       = pc_decode_reg;
  assign instruction_out = instr_reg;
  assign valid_out       = valid_reg;

`ifdef FETCH_REDIRECT_COUNT_EN
  logic [15:0] redirect_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_count_reg <= '0;
    end else if (branch_taken && redirect_count_reg != 16'hFFFF) begin
      redirect_count_reg <= redirect_count_reg + 16'd1;
    end
  end

  assign redirect_count = redirect_count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a behavioural synchronous ROM.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        nop, branch_taken;
  logic [15:0] branch_address;
  logic [15:0] rom_address, rom_q, pc_decode, instruction_out;
  logic        valid_out;

  logic        nop2, br2;
  logic [15:0] baddr2;
  logic [15:0] rom_address2, rom_q2, pc_decode2, instruction_out2;
  logic        valid_out2;

`ifdef FETCH_REDIRECT_COUNT_EN
  logic [15:0] redirect_count, redirect_count2;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .nop             (nop),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .rom_address     (rom_address),
    .rom_q           (rom_q),
    .pc_decode       (pc_decode),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
`ifdef FETCH_REDIRECT_COUNT_EN
    ,
    .redirect_count  (redirect_count)
`endif
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
    .clk             (clk),
    .reset           (reset),
    .nop             (nop2),
    .branch_taken    (br2),
    .branch_address  (baddr2),
    .rom_address     (rom_address2),
    .rom_q           (rom_q2),
    .pc_decode       (pc_decode2),
    .instruction_out (instruction_out2),
    .valid_out       (valid_out2)
`ifdef FETCH_REDIRECT_COUNT_EN
    ,
    .redirect_count  (redirect_count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word[i] = 16'h1000 + i, one cycle read latency
  always @(posedge clk) begin
    rom_q  <= 16'h1000 + rom_address;
    rom_q2 <= 16'h1000 + rom_address2;
  end

  typedef struct {
    logic        nop;
    logic        br;
    logic [15:0] baddr;
    logic [15:0] ra;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(logic n, logic b, logic [15:0] ba, logic [15:0] ra,
                              logic v, logic [15:0] ins, logic [15:0] pc);
    vec_t r;
    r.nop = n; r.br = b; r.baddr = ba; r.ra = ra;
    r.valid = v; r.instr = ins; r.pc = pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] pc);
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    chk({tag, ".instr"}, {16'd0, instruction_out}, {16'd0, ins});
    chk({tag, ".pc"}, {16'd0, pc_decode}, {16'd0, pc});
  endtask

  task automatic chk_out2(input string tag, input logic v, input logic [15:0] ins,
                          input logic [15:0] pc);
    chk({tag, ".valid"}, {31'd0, valid_out2}, {31'd0, v});
    chk({tag, ".instr"}, {16'd0, instruction_out2}, {16'd0, ins});
    chk({tag, ".pc"}, {16'd0, pc_decode2}, {16'd0, pc});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(0, 0, 16'h0000, 16'h0001, 1, 16'h1000, 16'h0000);
    vecs[2]  = mk(0, 0, 16'h0000, 16'h0002, 1, 16'h1001, 16'h0001);
    vecs[3]  = mk(0, 0, 16'h0000, 16'h0003, 1, 16'h1002, 16'h0002);
    vecs[4]  = mk(0, 0, 16'h0000, 16'h0004, 1, 16'h1003, 16'h0003);
    vecs[5]  = mk(1, 0, 16'h0000, 16'h0004, 1, 16'h1003, 16'h0003);
    vecs[6]  = mk(1, 0, 16'h0000, 16'h0004, 1, 16'h1003, 16'h0003);
    vecs[7]  = mk(1, 0, 16'h0000, 16'h0004, 1, 16'h1003, 16'h0003);
    vecs[8]  = mk(0, 0, 16'h0000, 16'h0005, 1, 16'h1004, 16'h0004);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h0006, 1, 16'h1005, 16'h0005);
    vecs[10] = mk(0, 1, 16'h0020, 16'h0007, 0, 16'h0000, 16'h0005);
    vecs[11] = mk(0, 0, 16'h0000, 16'h0020, 0, 16'h0000, 16'h0005);
    vecs[12] = mk(0, 0, 16'h0000, 16'h0021, 1, 16'h1020, 16'h0020);
    vecs[13] = mk(1, 1, 16'h0040, 16'h0021, 0, 16'h0000, 16'h0020);
    vecs[14] = mk(1, 0, 16'h0000, 16'h0040, 0, 16'h0000, 16'h0020);
    vecs[15] = mk(0, 0, 16'h0000, 16'h0040, 0, 16'h0000, 16'h0020);
    vecs[16] = mk(0, 0, 16'h0000, 16'h0041, 1, 16'h1040, 16'h0040);
    vecs[17] = mk(1, 1, 16'h0050, 16'h0041, 0, 16'h0000, 16'h0040);
    vecs[18] = mk(0, 0, 16'h0000, 16'h0050, 0, 16'h0000, 16'h0040);
    vecs[19] = mk(0, 0, 16'h0000, 16'h0051, 1, 16'h1050, 16'h0050);
    vecs[20] = mk(0, 1, 16'h0060, 16'h0052, 0, 16'h0000, 16'h0050);
    vecs[21] = mk(0, 1, 16'h0070, 16'h0060, 0, 16'h0000, 16'h0050);
    vecs[22] = mk(0, 0, 16'h0000, 16'h0070, 0, 16'h0000, 16'h0050);
    vecs[23] = mk(0, 0, 16'h0000, 16'h0071, 1, 16'h1070, 16'h0070);
    vecs[24] = mk(0, 0, 16'h0000, 16'h0072, 1, 16'h1071, 16'h0071);
    vecs[25] = mk(0, 1, 16'hFFFF, 16'h0073, 0, 16'h0000, 16'h0071);
    vecs[26] = mk(0, 0, 16'h0000, 16'hFFFF, 0, 16'h0000, 16'h0071);
    vecs[27] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0FFF, 16'hFFFF);
    vecs[28] = mk(0, 0, 16'h0000, 16'h0001, 1, 16'h1000, 16'h0000);

    reset = 1'b1; nop = 1'b0; branch_taken = 1'b0; branch_address = 16'h0000;
    nop2 = 1'b0; br2 = 1'b0; baddr2 = 16'h0000;
    step();
    step();
    chk_out("reset", 1'b0, 16'h0000, 16'h0000);
    chk("reset.rom_address", {16'd0, rom_address}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      nop = vecs[i].nop;
      branch_taken = vecs[i].br;
      branch_address = vecs[i].baddr;
      @(negedge clk);
      chk($sformatf("v%0d.rom_address", i), {16'd0, rom_address}, {16'd0, vecs[i].ra});
      step();
      chk_out($sformatf("v%0d", i), vecs[i].valid, vecs[i].instr, vecs[i].pc);
      $display("vec %0d nop=%0b br=%0b addr=%h -> valid=%0b instr=%h pc=%h",
               i, vecs[i].nop, vecs[i].br, vecs[i].baddr, valid_out, instruction_out, pc_decode);
    end
    nop = 1'b0; branch_taken = 1'b0;

    // Reset with RESET_PC=FFFE: wrap through 0000
    reset = 1'b1;
    step();
    chk_out2("r2.reset", 1'b0, 16'h0000, 16'h0000);
    reset = 1'b0;
    step();
    chk_out2("r2.fill", 1'b0, 16'h0000, 16'h0000);
    step();
    chk_out2("r2.e0", 1'b1, 16'h0FFE, 16'hFFFE);
    chk_out("r1.first", 1'b1, 16'h1000, 16'h0000);
    step();
    chk_out2("r2.e1", 1'b1, 16'h0FFF, 16'hFFFF);
    step();
    chk_out2("r2.e2", 1'b1, 16'h1000, 16'h0000);
    step();
    chk_out2("r2.e3", 1'b1, 16'h1001, 16'h0001);
    $display("wrap sequence done pc2=%h instr2=%h", pc_decode2, instruction_out2);

    // Mid-stream reset overriding redirect and stall
    reset = 1'b1; nop = 1'b1; branch_taken = 1'b1; branch_address = 16'h0033;
    step();
    chk_out("mid.reset", 1'b0, 16'h0000, 16'h0000);
    reset = 1'b0; nop = 1'b0; branch_taken = 1'b0;
    step();
    chk_out("mid.fill", 1'b0, 16'h0000, 16'h0000);
    step();
    chk_out("mid.first", 1'b1, 16'h1000, 16'h0000);
    chk_out2("mid2.first", 1'b1, 16'h0FFE, 16'hFFFE);
    step();
    chk_out("mid.second", 1'b1, 16'h1001, 16'h0001);
    $display("mid-stream reset done pc=%h instr=%h", pc_decode, instruction_out);

`ifdef FETCH_REDIRECT_COUNT_EN
    reset = 1'b1;
    step();
    chk("cnt.reset", {16'd0, redirect_count}, 32'd0);
    reset = 1'b0; branch_taken = 1'b1; branch_address = 16'h0010;
    repeat (4) step();
    branch_taken = 1'b0;
    step();
    chk("cnt.four", {16'd0, redirect_count}, 32'd4);
    branch_taken = 1'b1;
    repeat (65531) step();
    chk("cnt.max", {16'd0, redirect_count}, 32'h0000FFFF);
    step();
    chk("cnt.sat", {16'd0, redirect_count}, 32'h0000FFFF);
    branch_taken = 1'b0;
    reset = 1'b1;
    step();
    chk("cnt.clear", {16'd0, redirect_count}, 32'd0);
    reset = 1'b0;
    $display("redirect counter sequence done count=%h", redirect_count);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
